// File: rtl/uart_pkg.sv
// Shared UART definitions: rate codes, baud table, divisor math, FSM states.
// Imported by both the transmit and receive halves of the link.
package uart_pkg;

  localparam logic [1:0] RATE_9600   = 2'b00;
  localparam logic [1:0] RATE_19200  = 2'b01;
  localparam logic [1:0] RATE_57600  = 2'b10;
  localparam logic [1:0] RATE_115200 = 2'b11;

  localparam int unsigned BAUD_9600   = 9600;
  localparam int unsigned BAUD_19200  = 19200;
  localparam int unsigned BAUD_57600  = 57600;
  localparam int unsigned BAUD_115200 = 115200;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uartState_e;

  function automatic int unsigned baudOf(
    input logic [1:0] rate
  );
    int unsigned baud;
    case (rate)
      RATE_9600:  baud = BAUD_9600;
      RATE_19200: baud = BAUD_19200;
      RATE_57600: baud = BAUD_57600;
      default:    baud = BAUD_115200;
    endcase
    return baud;
  endfunction

  // Round to nearest clock count per bit.
  function automatic int unsigned divisorOf(
    input int unsigned clkHz,
    input logic [1:0]  rate
  );
    int unsigned baud;
    baud = baudOf(rate);
    return (clkHz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter.
// Source drives byte, rate and valid; transmitter answers with ready.
interface uart_tx_if;

  logic [7:0] iData;
  logic [1:0] iRate;
  logic       iValid;
  logic       oReady;

  modport master (
    output iData,
    output iRate,
    output iValid,
    input  oReady
  );

  modport slave (
    input  iData,
    input  iRate,
    input  iValid,
    output oReady
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period down-counter; period latched on load, bitEnd on terminal count.
// Reloads itself every period while run is high.
module uart_baud_gen #(
  parameter int DIV_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] loadVal,
  output logic             bitEnd
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] periodQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      periodQ <= '0;
    end else if (load) begin
      cnt     <= loadVal;
      periodQ <= loadVal;
    end else if (run) begin
      if (cnt == '0)
        cnt <= periodQ;
      else
        cnt <= cnt - DIV_W'(1);
    end
  end

  assign bitEnd = run && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, four selectable baud rates.
// TX is registered from the next-state decode so it moves with the FSM.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          DIV_W  = 14
) (
  input  logic       clk,
  input  logic       reset,
  uart_tx_if.slave   bus,
  output logic       TX,
  output logic       oBusy,
  output logic       oDone
);

  localparam logic [DIV_W-1:0] DIVM1_9600 =
    DIV_W'(divisorOf(CLK_HZ, RATE_9600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_19200 =
    DIV_W'(divisorOf(CLK_HZ, RATE_19200) - 1);
  localparam logic [DIV_W-1:0] DIVM1_57600 =
    DIV_W'(divisorOf(CLK_HZ, RATE_57600) - 1);
  localparam logic [DIV_W-1:0] DIVM1_115200 =
    DIV_W'(divisorOf(CLK_HZ, RATE_115200) - 1);

  uartState_e       state;
  uartState_e       stateNext;
  logic [7:0]       shiftQ;
  logic [7:0]       shiftNext;
  logic [2:0]       idxQ;
  logic [2:0]       idxNext;
  logic             txQ;
  logic             txNext;
  logic             doneQ;
  logic             doneNext;
  logic             load;
  logic             bitEnd;
  logic [DIV_W-1:0] divSel;

  always_comb begin
    divSel = DIVM1_115200;
    unique case (1'b1)
      bus.iRate == RATE_9600:   divSel = DIVM1_9600;
      bus.iRate == RATE_19200:  divSel = DIVM1_19200;
      bus.iRate == RATE_57600:  divSel = DIVM1_57600;
      bus.iRate == RATE_115200: divSel = DIVM1_115200;
      default: ;
    endcase
  end

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) baudGen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .run     (state != IDLE),
    .loadVal (divSel),
    .bitEnd  (bitEnd)
  );

  always_comb begin
    stateNext = state;
    shiftNext = shiftQ;
    idxNext   = idxQ;
    doneNext  = 1'b0;
    load      = 1'b0;
    txNext    = 1'b1;
    unique case (state)
      IDLE: begin
        if (bus.iValid) begin
          load      = 1'b1;
          shiftNext = bus.iData;
          idxNext   = '0;
          stateNext = START;
        end
      end
      START: begin
        if (bitEnd)
          stateNext = DATA;
      end
      DATA: begin
        if (bitEnd) begin
          shiftNext = {1'b0, shiftQ[7:1]};
          idxNext   = idxQ + 3'd1;
          if (idxQ == 3'd7)
            stateNext = STOP;
        end
      end
      STOP: begin
        if (bitEnd) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    unique case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shiftQ <= '0;
      idxQ   <= '0;
      txQ    <= 1'b1;
      doneQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      shiftQ <= shiftNext;
      idxQ   <= idxNext;
      txQ    <= txNext;
      doneQ  <= doneNext;
    end
  end

  assign bus.oReady = (state == IDLE);
  assign oBusy      = (state != IDLE);
  assign TX         = txQ;
  assign oDone      = doneQ;

endmodule
